// File: rtl/gray_counter.sv
// Registered Gray-code counter with up/down, enable and load, plus an independent
// registered Gray-to-binary decode channel. Define GRAY_CNT_SAT_EN to saturate at the bounds.
module gray_counter #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  input  logic [WIDTH-1:0] gin,
  input  logic             gin_vld,
  output logic [WIDTH-1:0] bout,
  output logic             bout_vld
);

  localparam logic [WIDTH-1:0] MaxVal   = '1;
  localparam logic [WIDTH-1:0] RstGray  = RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bout_q, bout_d;
  logic             wrap_q, wrap_d;
  logic             bout_vld_q;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = ld_val;
    end else if (en) begin
      if (up) begin
        if (bin_q == MaxVal) begin
          wrap_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          bin_d  = MaxVal;
`else
          bin_d  = '0;
`endif
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          wrap_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          bin_d  = '0;
`else
          bin_d  = MaxVal;
`endif
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    // Gray derives from the next binary value so both registers stay coherent.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bout_d = bout_q;
    if (gin_vld) begin
      for (int i = 0; i < WIDTH; i++) begin
        bout_d[i] = ^(gin >> i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= RST_VAL;
      gray_q     <= RstGray;
      wrap_q     <= 1'b0;
      bout_q     <= '0;
      bout_vld_q <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      wrap_q     <= wrap_d;
      bout_q     <= bout_d;
      bout_vld_q <= gin_vld;
    end
  end

  assign bin      = bin_q;
  assign gray     = gray_q;
  assign wrap     = wrap_q;
  assign bout     = bout_q;
  assign bout_vld = bout_vld_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a behavioural model pushes expected outputs per driven
// cycle; they are popped and compared one cycle later.
module tb_gray_counter;

  localparam int unsigned W    = 4;
  localparam int unsigned MAXV = (1 << W) - 1;
  localparam int unsigned RSTV = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, up = 1'b0, load = 1'b0, gin_vld = 1'b0;
  logic [W-1:0] ld_val = '0, gin = '0;
  logic [W-1:0] bin, gray, bout;
  logic         wrap, bout_vld;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic [W-1:0] bout;
    logic         vld;
    logic         step;
    logic [W-1:0] prev_gray;
  } exp_t;

  exp_t q_exp[$];

  int total = 0;
  int bad   = 0;

  int unsigned  m_bin  = RSTV;
  logic [W-1:0] m_bout = '0;
  logic [W-1:0] m_gray = '0;

  gray_counter #(
    .WIDTH  (W),
    .RST_VAL(W'(RSTV))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .ld_val  (ld_val),
    .bin     (bin),
    .gray    (gray),
    .wrap    (wrap),
    .gin     (gin),
    .gin_vld (gin_vld),
    .bout    (bout),
    .bout_vld(bout_vld)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input int unsigned b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
    logic [W-1:0] r;
    logic         acc;
    acc = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      r[i] = acc;
    end
    return r;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lv, input logic [W-1:0] g, input logic gv);
    exp_t x;
    exp_t o;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; ld_val = lv; gin = g; gin_vld = gv;
    x.prev_gray = m_gray;
    x.step      = 1'b0;
    x.wrap      = 1'b0;
    if (r) begin
      m_bin  = RSTV;
      m_bout = '0;
      x.vld  = 1'b0;
    end else begin
      if (l) begin
        m_bin = int'(lv);
      end else if (e) begin
        if (u) begin
          if (m_bin == MAXV) begin
            x.wrap = 1'b1;
`ifndef GRAY_CNT_SAT_EN
            m_bin  = 0;
            x.step = 1'b1;
`endif
          end else begin
            m_bin  = m_bin + 1;
            x.step = 1'b1;
          end
        end else begin
          if (m_bin == 0) begin
            x.wrap = 1'b1;
`ifndef GRAY_CNT_SAT_EN
            m_bin  = MAXV;
            x.step = 1'b1;
`endif
          end else begin
            m_bin  = m_bin - 1;
            x.step = 1'b1;
          end
        end
      end
      if (gv) m_bout = from_gray(g);
      x.vld = gv;
    end
    m_gray = to_gray(m_bin);
    x.bin  = W'(m_bin);
    x.gray = m_gray;
    x.bout = m_bout;
    q_exp.push_back(x);
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      o = q_exp.pop_front();
      check_eq("bin", 32'(bin), 32'(o.bin));
      check_eq("gray", 32'(gray), 32'(o.gray));
      check_eq("wrap", 32'(wrap), 32'(o.wrap));
      check_eq("bout", 32'(bout), 32'(o.bout));
      check_eq("bout_vld", 32'(bout_vld), 32'(o.vld));
      if (o.step) check_eq("gray_1bit", 32'($countones(gray ^ o.prev_gray)), 32'd1);
    end
  endtask

  initial begin
    // Reset with counter and decode requests pending.
    cycle(1, 1, 1, 0, '0, 4'b1000, 1);
    cycle(1, 0, 0, 0, '0, '0, 0);
    // Full up-run 0..15 and back to 0.
    for (int i = 0; i < 16; i++) cycle(0, 1, 1, 0, '0, '0, 0);
    // Load 0 beats a down-step, then step down across the boundary.
    cycle(0, 1, 0, 1, 4'd0, '0, 0);
    cycle(0, 1, 0, 0, '0, '0, 0);
    // Load 9 beats an up-step, then step up.
    cycle(0, 1, 1, 1, 4'd9, '0, 0);
    cycle(0, 1, 1, 0, '0, '0, 0);
    // Decode stream then idle.
    cycle(0, 0, 0, 0, '0, 4'b1000, 1);
    cycle(0, 0, 0, 0, '0, 4'b1101, 1);
    cycle(0, 0, 0, 0, '0, 4'b0000, 1);
    cycle(0, 0, 0, 0, '0, 4'b1111, 0);
    cycle(0, 0, 0, 0, '0, 4'b0110, 0);
    // Mid-operation reset overriding count and decode.
    cycle(0, 1, 1, 1, 4'd6, 4'b0101, 1);
    cycle(1, 1, 1, 0, '0, 4'b0101, 1);
    // Bound behaviour: three up-steps at 15, one down-step at 0.
    cycle(0, 0, 0, 1, 4'd15, '0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, '0, '0, 0);
    cycle(0, 0, 0, 1, 4'd0, '0, 0);
    cycle(0, 1, 0, 0, '0, '0, 0);
    cycle(0, 0, 0, 0, '0, '0, 0);
    // Randomised mix with direction changes and occasional load/reset.
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 31) == 0), $urandom_range(0, 3) != 0, 1'($urandom),
            ($urandom_range(0, 15) == 0), W'($urandom), W'($urandom), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
